// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//   Step-tick prescaler plus one-of-N position sequencer driving an LED bank.
//   Patterns: rotate-left, rotate-right, ping-pong, fill-bar.
//   Optional build macro LED_PWM_EN adds a duty input and a free-running
//   4-bit PWM counter that gates the LED drive (pos/step_pulse unaffected).
//
//   Ping-pong direction state:
//   state    | meaning
//   ---------+-----------------------------------------------
//   DIR_UP   | ping-pong walks toward N_LED-1
//   DIR_DOWN | ping-pong walks toward 0
//   (direction only changes while ping-pong is the active mode)

module led_pattern_sequencer #(
    parameter int N_LED    = 8,
    parameter int STEP_DIV = 600,
    parameter int POS_W    = $clog2(N_LED)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
`ifdef LED_PWM_EN
    input  logic [3:0]       duty,
`endif
    output logic [N_LED-1:0] led_select,
    output logic             step_pulse,
    output logic [POS_W-1:0] pos
);

    localparam int               PS_W     = $clog2(STEP_DIV);
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(STEP_DIV - 1);
    localparam logic [PS_W-1:0]  PS_ONE   = PS_W'(1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LED - 1);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
    localparam logic [N_LED-1:0] LED_ONE  = N_LED'(1);

    typedef enum logic [1:0] {
        MODE_ROT_L = 2'b00,
        MODE_ROT_R = 2'b01,
        MODE_PING  = 2'b10,
        MODE_FILL  = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [PS_W-1:0]  prescaler;
    logic             tick;
    mode_t            mode_cur;
    dir_t             dir, dir_nxt, dir_eff;
    logic [POS_W-1:0] pos_nxt;
    logic [N_LED-1:0] pattern, pattern_nxt;
    logic [N_LED-1:0] onehot_nxt, fill_nxt;

    assign tick     = en && (prescaler == PS_LAST);
    assign mode_cur = mode_t'(mode);

    // Prescaler: counts while enabled, holds when frozen, wraps on tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else if (en) begin
            prescaler <= prescaler + PS_ONE;
        end
    end

    // Next position and direction, evaluated only on a tick.
    always_comb begin
        pos_nxt = pos;
        dir_nxt = dir;
        dir_eff = dir;
        if (tick) begin
            case (mode_cur)
                MODE_ROT_L, MODE_FILL: begin
                    pos_nxt = (pos >= POS_LAST) ? '0 : pos + POS_ONE;
                end
                MODE_ROT_R: begin
                    pos_nxt = (pos == '0) ? POS_LAST : pos - POS_ONE;
                end
                MODE_PING: begin
                    // Flip first if pointing out of range, so pos never escapes.
                    if (dir == DIR_UP && pos >= POS_LAST) begin
                        dir_eff = DIR_DOWN;
                    end else if (dir == DIR_DOWN && pos == '0) begin
                        dir_eff = DIR_UP;
                    end
                    pos_nxt = (dir_eff == DIR_UP) ? pos + POS_ONE : pos - POS_ONE;
                    dir_nxt = dir_eff;
                    if (pos_nxt == POS_LAST) begin
                        dir_nxt = DIR_DOWN;
                    end else if (pos_nxt == '0) begin
                        dir_nxt = DIR_UP;
                    end
                end
                default: begin
                    pos_nxt = pos;
                end
            endcase
        end
    end

    // Pattern decode of the next position; only loaded on a tick.
    always_comb begin
        onehot_nxt = '0;
        fill_nxt   = '0;
        for (int i = 0; i < N_LED; i++) begin
            onehot_nxt[i] = (pos_nxt == POS_W'(i));
            fill_nxt[i]   = (POS_W'(i) <= pos_nxt);
        end
        pattern_nxt = pattern;
        if (tick) begin
            pattern_nxt = (mode_cur == MODE_FILL) ? fill_nxt : onehot_nxt;
        end
    end

    // Sequencer state register: position, direction, pattern, step pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos        <= '0;
            dir        <= DIR_UP;
            pattern    <= LED_ONE;
            step_pulse <= 1'b0;
        end else begin
            pos        <= pos_nxt;
            dir        <= dir_nxt;
            pattern    <= pattern_nxt;
            step_pulse <= tick;
        end
    end

`ifdef LED_PWM_EN
    logic [3:0] pwm_cnt;
    logic       pwm_on;

    assign pwm_on = (pwm_cnt < duty);

    // Free-running PWM counter, independent of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
        end
    end

    // Gated LED drive; pattern changes land on the same edge as step_pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_select <= '0;
        end else begin
            led_select <= pattern_nxt & {N_LED{pwm_on}};
        end
    end
`else
    assign led_select = pattern;
`endif

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with N_LED=8, STEP_DIV=4.
module tb_led_pattern_sequencer;

    localparam int N_LED    = 8;
    localparam int STEP_DIV = 4;
    localparam int POS_W    = 3;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [1:0]       mode;
    logic [N_LED-1:0] led_select;
    logic             step_pulse;
    logic [POS_W-1:0] pos;
`ifdef LED_PWM_EN
    logic [3:0]       duty;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    led_pattern_sequencer #(.N_LED(N_LED), .STEP_DIV(STEP_DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
`ifdef LED_PWM_EN
        .duty       (duty),
`endif
        .led_select (led_select),
        .step_pulse (step_pulse),
        .pos        (pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // LED values are only comparable in the ungated build.
    task automatic check_led(input string tag, input logic [31:0] exp);
`ifndef LED_PWM_EN
        check_val(tag, 32'(led_select), exp);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Wait for the next step_pulse (sampled on falling edges), bounded.
    task automatic next_tick(output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (step_pulse !== 1'b1 && waited < 20);
    endtask

    logic [7:0] rl_led   [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [7:0] rr_led   [3] = '{8'h80, 8'h40, 8'h20};
    logic [2:0] rr_pos   [3] = '{3'd7, 3'd6, 3'd5};
    logic [2:0] pp_pos   [15] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6,
                                  3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};
    logic [7:0] fill_led [8] = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h01};

    initial begin
        int w;
        int lit;
        rst_n = 1'b0;
        en    = 1'b1;
        mode  = 2'b00;
`ifdef LED_PWM_EN
        duty  = 4'd15;
`endif

        // Rotate-left from reset.
        do_reset();
        check_led("rst_led", 32'h01);
        check_val("rst_pos", 32'(pos), 32'd0);
        check_val("rst_step", 32'(step_pulse), 32'd0);
        for (int k = 0; k < 8; k++) begin
            next_tick(w);
            check_val("rl_gap", w, STEP_DIV);
            check_led("rl_led", 32'(rl_led[k]));
            check_val("rl_pos", 32'(pos), 32'((k + 1) % 8));
        end
        @(negedge clk);
        check_val("rl_step_low", 32'(step_pulse), 32'd0);

        // Rotate-right from reset.
        mode = 2'b01;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            next_tick(w);
            check_val("rr_gap", w, STEP_DIV);
            check_led("rr_led", 32'(rr_led[k]));
            check_val("rr_pos", 32'(pos), 32'(rr_pos[k]));
        end

        // Ping-pong: endpoints not repeated.
        mode = 2'b10;
        do_reset();
        for (int k = 0; k < 15; k++) begin
            next_tick(w);
            check_val("pp_pos", 32'(pos), 32'(pp_pos[k]));
        end

        // Fill-bar, then mid-period switch to rotate-left at pos 3.
        mode = 2'b11;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            next_tick(w);
            check_led("fill_led", 32'(fill_led[k]));
        end
        for (int k = 0; k < 3; k++) next_tick(w);
        check_val("fill_pos3", 32'(pos), 32'd3);
        check_led("fill_led3", 32'h0F);
        @(negedge clk);
        @(negedge clk);
        mode = 2'b00;
        @(negedge clk);
        check_led("mode_hold_led", 32'h0F);
        check_val("mode_hold_pos", 32'(pos), 32'd3);
        next_tick(w);
        check_val("mode_sw_gap", w, 1);
        check_val("mode_sw_pos", 32'(pos), 32'd4);
        check_led("mode_sw_led", 32'h10);

        // Freeze with en=0 at prescaler=2, then async reset between edges.
        mode = 2'b00;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        en = 1'b0;
        lit = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (step_pulse !== 1'b0) lit++;
        end
        check_val("frz_step", lit, 0);
        check_val("frz_pos", 32'(pos), 32'd0);
        check_led("frz_led", 32'h01);
        en = 1'b1;
        next_tick(w);
        check_val("resume_gap", w, 2);
        check_val("resume_pos", 32'(pos), 32'd1);
        check_led("resume_led", 32'h02);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_pos", 32'(pos), 32'd0);
        check_val("arst_step", 32'(step_pulse), 32'd0);
        check_led("arst_led", 32'h01);
        @(negedge clk);
        rst_n = 1'b1;

        // Direction pointing outward on ping-pong entry flips before stepping.
        mode = 2'b10;
        for (int k = 0; k < 7; k++) next_tick(w);
        check_val("pp_at7", 32'(pos), 32'd7);
        mode = 2'b00;
        next_tick(w);
        check_val("rl_wrap0", 32'(pos), 32'd0);
        mode = 2'b10;
        next_tick(w);
        check_val("pp_entry_pos", 32'(pos), 32'd1);
        next_tick(w);
        check_val("pp_entry_pos2", 32'(pos), 32'd2);

`ifdef LED_PWM_EN
        // Gated drive: lit cycles of the current LED over one PWM period.
        mode = 2'b00;
        en   = 1'b0;
        duty = 4'd8;
        @(negedge clk);
        lit = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (led_select[pos] === 1'b1) lit++;
        end
        check_val("pwm_duty8", lit, 8);
        duty = 4'd0;
        @(negedge clk);
        lit = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (led_select !== '0) lit++;
        end
        check_val("pwm_duty0", lit, 0);
        rst_n = 1'b0;
        #1;
        check_val("pwm_rst_led", 32'(led_select), 32'd0);
        rst_n = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
